// File: rtl/score_pkg.sv
`default_nettype none
// ============================================================================
// Module      : score_pkg
// Description : Shared result codes, game states and winner codes for the
//               score tracker.
// Revision    : 1.0 - initial release
// ============================================================================
package score_pkg;

    typedef enum logic [1:0] {
        RES_NONE = 2'b00,
        RES_DRAW = 2'b01,
        RES_P1   = 2'b10,
        RES_P2   = 2'b11
    } result_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PLAY = 2'b01,
        DONE = 2'b10
    } state_t;

    // Winner reporting shares the result encoding; "draw" means a tied game.
    localparam result_t WIN_NONE = RES_NONE;
    localparam result_t WIN_TIE  = RES_DRAW;
    localparam result_t WIN_P1   = RES_P1;
    localparam result_t WIN_P2   = RES_P2;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that holds at all-ones; clear beats increment.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (inc && (r_q != {W{1'b1}})) begin
            r_q <= r_q + 1'b1;
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/score_tracker.sv
`default_nettype none
// ============================================================================
// Module      : score_tracker
// Description : Round/win/lose/draw scoreboard with streak tracking and a
//               first-to-N / max-rounds game state machine.
// Revision    : 1.0 - initial release
// ============================================================================
module score_tracker
    import score_pkg::*;
#(
    parameter int CNT_W      = 4,
    parameter int WIN_TARGET = 3,
    parameter int MAX_ROUNDS = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             result_valid,
    input  logic [1:0]       matchresult,
    output logic [CNT_W-1:0] round,
    output logic [CNT_W-1:0] win,
    output logic [CNT_W-1:0] lose,
    output logic [CNT_W-1:0] draw,
    output logic [CNT_W-1:0] streak,
    output logic             streak_p2,
    output logic             busy,
    output logic             game_over,
    output logic [1:0]       winner,
    output logic             err
);

    generate
        if ((WIN_TARGET < 1) || (WIN_TARGET > (2**CNT_W) - 1)) begin : g_bad_target
            $fatal(1, "score_tracker: WIN_TARGET out of range");
        end
        if ((MAX_ROUNDS < WIN_TARGET) || (MAX_ROUNDS > (2**CNT_W) - 1)) begin : g_bad_rounds
            $fatal(1, "score_tracker: MAX_ROUNDS out of range");
        end
    endgenerate

    localparam logic [CNT_W-1:0] TARGET_M1 = CNT_W'(WIN_TARGET - 1);
    localparam logic [CNT_W-1:0] ROUNDS_M1 = CNT_W'(MAX_ROUNDS - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_streak;
    logic             r_streak_p2;
    result_t          r_winner;
    logic             r_err;

    logic             w_accept;
    logic             w_legal;
    logic             w_inc_p1;
    logic             w_inc_p2;
    logic             w_inc_draw;
    logic             w_ends;
    logic [CNT_W:0]   w_win_f;
    logic [CNT_W:0]   w_lose_f;
    result_t          w_final;

    // start takes priority: a result in the same cycle is discarded.
    assign w_accept   = result_valid && (r_state == PLAY) && !start;
    assign w_legal    = w_accept && (matchresult != RES_NONE);
    assign w_inc_p1   = w_legal && (matchresult == RES_P1);
    assign w_inc_p2   = w_legal && (matchresult == RES_P2);
    assign w_inc_draw = w_legal && (matchresult == RES_DRAW);

    assign w_ends = w_legal && ((w_inc_p1 && (win  == TARGET_M1)) ||
                                (w_inc_p2 && (lose == TARGET_M1)) ||
                                (round == ROUNDS_M1));

    // Final tally after the deciding strobe, one bit wider so it cannot wrap.
    assign w_win_f  = {1'b0, win}  + {{CNT_W{1'b0}}, w_inc_p1};
    assign w_lose_f = {1'b0, lose} + {{CNT_W{1'b0}}, w_inc_p2};

    always_comb begin
        w_final = WIN_TIE;
        if (w_win_f > w_lose_f) begin
            w_final = WIN_P1;
        end else if (w_lose_f > w_win_f) begin
            w_final = WIN_P2;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = PLAY;
            PLAY:    if (start) w_state_next = PLAY;
                     else if (w_ends) w_state_next = DONE;
            DONE:    if (start) w_state_next = PLAY;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_streak    <= '0;
            r_streak_p2 <= 1'b0;
            r_winner    <= WIN_NONE;
            r_err       <= 1'b0;
        end else begin
            r_err <= w_accept && (matchresult == RES_NONE);
            if (start) begin
                r_streak    <= '0;
                r_streak_p2 <= 1'b0;
                r_winner    <= WIN_NONE;
            end else begin
                if (w_ends) begin
                    r_winner <= w_final;
                end
                if (w_inc_draw) begin
                    r_streak <= '0;
                end else if ((w_inc_p1 && !r_streak_p2) || (w_inc_p2 && r_streak_p2)) begin
                    if (r_streak != {CNT_W{1'b1}}) begin
                        r_streak <= r_streak + 1'b1;
                    end
                end else if (w_inc_p1 || w_inc_p2) begin
                    r_streak    <= CNT_W'(1);
                    r_streak_p2 <= w_inc_p2;
                end
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_round (
        .clk(clk), .reset(reset), .clr(start), .inc(w_legal), .q(round)
    );
    sat_counter #(.W(CNT_W)) u_win (
        .clk(clk), .reset(reset), .clr(start), .inc(w_inc_p1), .q(win)
    );
    sat_counter #(.W(CNT_W)) u_lose (
        .clk(clk), .reset(reset), .clr(start), .inc(w_inc_p2), .q(lose)
    );
    sat_counter #(.W(CNT_W)) u_draw (
        .clk(clk), .reset(reset), .clr(start), .inc(w_inc_draw), .q(draw)
    );

    assign streak    = r_streak;
    assign streak_p2 = r_streak_p2;
    assign busy      = (r_state == PLAY);
    assign game_over = (r_state == DONE);
    assign winner    = r_winner;
    assign err       = r_err;

endmodule
`default_nettype wire
